// File: rtl/apb4_master_param.sv
// APB4 requester: one valid/ready command becomes one SETUP/ACCESS transfer with a one-cycle response strobe.
// Define APB_TIMEOUT_EN to abort transfers whose slave holds PREADY low for TIMEOUT_CYC ACCESS cycles.
module apb4_master_param #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_strb,
  input  logic [2:0]            cmd_prot,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_W-1:0]     paddr,
  output logic [DATA_W-1:0]     pwdata,
  output logic [DATA_W/8-1:0]   pstrb,
  output logic [2:0]            pprot,
  input  logic [DATA_W-1:0]     prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int STRB_W = DATA_W / 8;

  if (ADDR_W < 2 || DATA_W < 8 || DATA_W > 32 || (DATA_W % 8) != 0 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("apb4_master_param: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e              state_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [STRB_W-1:0]   pstrb_q;
  logic [2:0]          pprot_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0]    tmo_cnt_q;
  logic                rsp_timeout_q;
`endif

  // Ready only in IDLE and never while reset is held, so no command slips in during reset.
  assign cmd_ready = (state_q == IDLE) && !preset;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            state_q  <= SETUP;
            psel_q   <= 1'b1;
            pwrite_q <= cmd_write;
            paddr_q  <= cmd_addr;
            pwdata_q <= cmd_write ? cmd_wdata : '0;
            pstrb_q  <= cmd_write ? cmd_strb : '0;
            pprot_q  <= cmd_prot;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
`ifdef APB_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        ACCESS: begin
          if (pready) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= pwrite_q ? '0 : prdata;
            rsp_err_q     <= pslverr;
`ifdef APB_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
          end else if (tmo_cnt_q == TMO_LAST) begin
            // This edge is the TIMEOUT_CYC-th wait cycle; give up on the slave.
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
          end else begin
            tmo_cnt_q     <= tmo_cnt_q + 1'b1;
`endif
          end
        end
        default: begin
          state_q   <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign pprot     = pprot_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

`ifdef APB_TIMEOUT_EN
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb4_master_param.sv
// Bench for apb4_master_param: transaction-level model checked every cycle plus directed cycle-exact checks.
// Timeout scenarios follow APB_TIMEOUT_EN the same way the design does.
`timescale 1ns/1ps
module tb_apb4_master_param;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int TMO    = 4;

`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              pclk = 1'b0;
  logic              preset;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_strb;
  logic [2:0]        cmd_prot;
  logic              rsp_valid, rsp_err, rsp_timeout;
  logic [DATA_W-1:0] rsp_rdata;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic [2:0]        pprot;
  logic [DATA_W-1:0] prdata;
  logic              pready, pslverr;

  int nChecks = 0;
  int nFails  = 0;

  apb4_master_param #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Transaction model: a transfer is "busy" from handshake to completion; age counts cycles since handshake.
  bit                mLive = 1'b0;
  bit                mBusy = 1'b0;
  int                mAge  = 0;
  int                mLow  = 0;
  logic              mWrite = 1'b0;
  logic [ADDR_W-1:0] mAddr  = '0;
  logic [DATA_W-1:0] mWdata = '0;
  logic [STRB_W-1:0] mStrb  = '0;
  logic [2:0]        mProt  = '0;
  logic              mRspValid = 1'b0;
  logic [DATA_W-1:0] mRdata = '0;
  logic              mErr = 1'b0;
  logic              mTo  = 1'b0;

  always @(posedge pclk) begin
    mLive <= 1'b1;
    if (preset) begin
      mBusy <= 1'b0; mAge <= 0; mLow <= 0;
      mWrite <= 1'b0; mAddr <= '0; mWdata <= '0; mStrb <= '0; mProt <= '0;
      mRspValid <= 1'b0; mRdata <= '0; mErr <= 1'b0; mTo <= 1'b0;
    end else begin
      mRspValid <= 1'b0;
      if (!mBusy) begin
        if (cmd_valid) begin
          mBusy  <= 1'b1; mAge <= 1; mLow <= 0;
          mWrite <= cmd_write;
          mAddr  <= cmd_addr;
          mWdata <= cmd_write ? cmd_wdata : '0;
          mStrb  <= cmd_write ? cmd_strb : '0;
          mProt  <= cmd_prot;
        end
      end else if (mAge == 1) begin
        mAge <= 2;
      end else if (pready) begin
        mBusy <= 1'b0; mRspValid <= 1'b1;
        mRdata <= mWrite ? '0 : prdata;
        mErr <= pslverr; mTo <= 1'b0;
      end else if (TO_EN && (mLow + 1 == TMO)) begin
        mBusy <= 1'b0; mRspValid <= 1'b1;
        mRdata <= '0; mErr <= 1'b1; mTo <= 1'b1;
      end else begin
        mLow <= mLow + 1;
      end
    end
  end

  always @(negedge pclk) begin
    if (mLive) begin
      checkOutput("m_cmd_ready", 32'(cmd_ready), 32'(mBusy == 1'b0 && preset == 1'b0));
      checkOutput("m_psel",      32'(psel),      32'(mBusy));
      checkOutput("m_penable",   32'(penable),   32'(mBusy && mAge >= 2));
      checkOutput("m_pwrite",    32'(pwrite),    32'(mWrite));
      checkOutput("m_paddr",     32'(paddr),     32'(mAddr));
      checkOutput("m_pwdata",    pwdata,         mWdata);
      checkOutput("m_pstrb",     32'(pstrb),     32'(mStrb));
      checkOutput("m_pprot",     32'(pprot),     32'(mProt));
      checkOutput("m_rsp_valid", 32'(rsp_valid), 32'(mRspValid));
      checkOutput("m_rsp_rdata", rsp_rdata,      mRdata);
      checkOutput("m_rsp_err",   32'(rsp_err),   32'(mErr));
      checkOutput("m_rsp_to",    32'(rsp_timeout), 32'(mTo));
    end
  end

  task automatic nextCycle();
    @(posedge pclk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s, input logic [2:0] p);
    cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_prot = p;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    preset = 1'b1; pready = 1'b0; pslverr = 1'b0; prdata = 32'hAAAA5555;
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    repeat (2) nextCycle();
    @(negedge pclk);
    checkOutput("rst_psel", 32'(psel), 32'd0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_paddr", 32'(paddr), 32'd0);
    nextCycle(); preset = 1'b0;
    @(negedge pclk);
    checkOutput("rst_exit_ready", 32'(cmd_ready), 32'd1);

    // Write, no wait states.
    nextCycle();
    applyStimulus(1'b1, 1'b1, 8'h24, 32'hDEADBEEF, 4'hF, 3'b010); pready = 1'b1;
    @(negedge pclk); checkOutput("wr_ready_n", 32'(cmd_ready), 32'd1);
    nextCycle(); applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    @(negedge pclk);
    checkOutput("wr_psel_n1", 32'(psel), 32'd1);
    checkOutput("wr_penable_n1", 32'(penable), 32'd0);
    checkOutput("wr_pstrb", 32'(pstrb), 32'hF);
    checkOutput("wr_pprot", 32'(pprot), 32'd2);
    checkOutput("wr_paddr", 32'(paddr), 32'h24);
    checkOutput("wr_pwdata", pwdata, 32'hDEADBEEF);
    nextCycle(); @(negedge pclk);
    checkOutput("wr_penable_n2", 32'(penable), 32'd1);
    nextCycle(); @(negedge pclk);
    checkOutput("wr_rsp_valid_n3", 32'(rsp_valid), 32'd1);
    checkOutput("wr_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("wr_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("wr_psel_n3", 32'(psel), 32'd0);
    nextCycle(); @(negedge pclk);
    checkOutput("wr_rsp_valid_n4", 32'(rsp_valid), 32'd0);

    // Read with two wait states.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 8'h10, 32'h12345678, 4'hF, 3'b001); pready = 1'b0; prdata = 32'h32;
    nextCycle(); applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    @(negedge pclk);
    checkOutput("rd_pstrb_setup", 32'(pstrb), 32'd0);
    checkOutput("rd_pwdata_setup", pwdata, 32'd0);
    nextCycle(); @(negedge pclk);
    checkOutput("rd_penable_n2", 32'(penable), 32'd1);
    nextCycle(); @(negedge pclk);
    checkOutput("rd_rsp_valid_n3", 32'(rsp_valid), 32'd0);
    nextCycle(); pready = 1'b1;
    @(negedge pclk); checkOutput("rd_pstrb_n4", 32'(pstrb), 32'd0);
    nextCycle(); pready = 1'b0;
    @(negedge pclk);
    checkOutput("rd_rsp_valid_n5", 32'(rsp_valid), 32'd1);
    checkOutput("rd_rsp_rdata", rsp_rdata, 32'h32);

    // Slave error on a write, then on a read.
    nextCycle();
    applyStimulus(1'b1, 1'b1, 8'h30, 32'h0BADF00D, 4'h3, 3'b000);
    pready = 1'b1; pslverr = 1'b1; prdata = 32'h5A5A5A5A;
    nextCycle(); applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    nextCycle(); nextCycle(); @(negedge pclk);
    checkOutput("err_wr_valid", 32'(rsp_valid), 32'd1);
    checkOutput("err_wr_err", 32'(rsp_err), 32'd1);
    checkOutput("err_wr_to", 32'(rsp_timeout), 32'd0);
    checkOutput("err_wr_rdata", rsp_rdata, 32'd0);
    nextCycle(); applyStimulus(1'b1, 1'b0, 8'h34, '0, '0, 3'b100);
    nextCycle(); applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    nextCycle(); nextCycle(); @(negedge pclk);
    checkOutput("err_rd_rdata", rsp_rdata, 32'h5A5A5A5A);
    checkOutput("err_rd_err", 32'(rsp_err), 32'd1);
    nextCycle(); pslverr = 1'b0;

    // Back-to-back with cmd_valid held.
    applyStimulus(1'b1, 1'b1, 8'h01, 32'h11, 4'h1, 3'b000); pready = 1'b1;
    nextCycle(); applyStimulus(1'b1, 1'b0, 8'h02, '0, '0, 3'b000); prdata = 32'h77;
    @(negedge pclk);
    checkOutput("b2b_ready_n1", 32'(cmd_ready), 32'd0);
    checkOutput("b2b_paddr1", 32'(paddr), 32'h01);
    nextCycle(); @(negedge pclk);
    checkOutput("b2b_psel_n2", 32'(psel), 32'd1);
    nextCycle(); @(negedge pclk);
    checkOutput("b2b_rsp_valid_n3", 32'(rsp_valid), 32'd1);
    checkOutput("b2b_ready_n3", 32'(cmd_ready), 32'd1);
    checkOutput("b2b_psel_gap", 32'(psel), 32'd0);
    nextCycle(); applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    @(negedge pclk);
    checkOutput("b2b_psel_n4", 32'(psel), 32'd1);
    checkOutput("b2b_penable_n4", 32'(penable), 32'd0);
    checkOutput("b2b_paddr2", 32'(paddr), 32'h02);
    nextCycle(); nextCycle(); @(negedge pclk);
    checkOutput("b2b_rsp_valid_n6", 32'(rsp_valid), 32'd1);
    checkOutput("b2b_rdata", rsp_rdata, 32'h77);

    // Bounded wait on a stalled slave.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 8'h44, '0, '0, 3'b000); pready = 1'b0; prdata = 32'h99;
    nextCycle(); applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
`ifdef APB_TIMEOUT_EN
    repeat (4) nextCycle();
    @(negedge pclk);
    checkOutput("to_penable_n5", 32'(penable), 32'd1);
    nextCycle(); @(negedge pclk);
    checkOutput("to_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("to_rsp_err", 32'(rsp_err), 32'd1);
    checkOutput("to_rsp_timeout", 32'(rsp_timeout), 32'd1);
    checkOutput("to_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("to_psel", 32'(psel), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 8'h48, '0, '0, 3'b000);
    nextCycle(); applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    repeat (3) nextCycle();
    nextCycle(); pready = 1'b1;
    nextCycle(); pready = 1'b0;
    @(negedge pclk);
    checkOutput("to_last_valid", 32'(rsp_valid), 32'd1);
    checkOutput("to_last_timeout", 32'(rsp_timeout), 32'd0);
    checkOutput("to_last_rdata", rsp_rdata, 32'h99);
`else
    repeat (100) nextCycle();
    @(negedge pclk);
    checkOutput("nto_psel", 32'(psel), 32'd1);
    checkOutput("nto_penable", 32'(penable), 32'd1);
    checkOutput("nto_rsp_valid", 32'(rsp_valid), 32'd0);
    nextCycle(); pready = 1'b1;
    nextCycle(); pready = 1'b0;
    @(negedge pclk);
    checkOutput("nto_done_valid", 32'(rsp_valid), 32'd1);
    checkOutput("nto_done_timeout", 32'(rsp_timeout), 32'd0);
    checkOutput("nto_done_rdata", rsp_rdata, 32'h99);
`endif

    // Reset during ACCESS wait states.
    nextCycle();
    applyStimulus(1'b1, 1'b1, 8'h60, 32'hCAFE0001, 4'hC, 3'b011); pready = 1'b0;
    nextCycle(); applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    nextCycle();
    nextCycle(); preset = 1'b1;
    @(negedge pclk);
    checkOutput("mid_rst_ready", 32'(cmd_ready), 32'd0);
    nextCycle(); @(negedge pclk);
    checkOutput("mid_rst_psel", 32'(psel), 32'd0);
    checkOutput("mid_rst_penable", 32'(penable), 32'd0);
    checkOutput("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    nextCycle(); preset = 1'b0; pready = 1'b1;
    @(negedge pclk);
    checkOutput("post_rst_ready", 32'(cmd_ready), 32'd1);
    checkOutput("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (3) nextCycle();
    @(negedge pclk);
    checkOutput("post_rst_idle_psel", 32'(psel), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/apb4_master_param.md
# apb4_master_param

Parametrised APB4 requester that turns a single-entry valid/ready command port into compliant APB4 SETUP/ACCESS transfers and returns read data plus error status on a one-cycle response strobe. It sits between a local controller and an APB4 slave, replacing the fixed 8-bit master. New capabilities are generic address/data widths, byte strobes (PSTRB), protection bits (PPROT), PSLVERR capture, and an optional bounded-wait timeout.

## Interface
- ADDR_W, 8, address width (≥2)
- DATA_W, 8, data width; multiple of 8, max 32
- TIMEOUT_CYC, 16, max ACCESS cycles with PREADY low before abort (only with timeout compiled in); ≥1, counter width $clog2(TIMEOUT_CYC+1)

Ports:
- pclk  in  1  clock, all logic on rising edge
- preset  in  1  synchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at posedge
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data
- cmd_strb  in  DATA_W/8  write byte strobes
- cmd_prot  in  3  PPROT value
- rsp_valid  out  1  one-cycle completion strobe
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_err  out  1  PSLVERR or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- psel, penable, pwrite  out  1  APB4 control
- paddr  out  ADDR_W; pwdata  out  DATA_W; pstrb  out  DATA_W/8; pprot  out  3
- prdata  in  DATA_W; pready  in  1; pslverr  in  1

## Operation
- FSM states IDLE, SETUP, ACCESS; reset state IDLE.
- IDLE: cmd_ready=1. On handshake, register addr/write/wdata/strb/prot and go to SETUP.
- SETUP: psel=1, penable=0. Unconditionally go to ACCESS.
- ACCESS: psel=1, penable=1. On pready=1, capture prdata (reads only) and pslverr, then go to IDLE.
- APB outputs hold constant from SETUP through the end of ACCESS.
- Reads drive pstrb=0 and pwdata=0.
- Outside SETUP/ACCESS: psel=penable=0; paddr/pwdata/pstrb/pprot/pwrite keep their last values.
- rsp_valid pulses for exactly one cycle, in the first IDLE cycle after completion. rsp_* fields stay valid until the next completion.
- A write with pslverr=1 gives rsp_err=1 and rsp_rdata=0.
- A read with pslverr=1 returns the captured prdata with rsp_err=1.
- cmd_ready=0 in SETUP/ACCESS. Commands presented then are ignored until IDLE and are not lost if held.

## Timing
- Reset value of every output is 0 (cmd_ready=1 after reset exits, since state=IDLE).
- Handshake at edge N gives SETUP in cycle N+1 and ACCESS in N+2.
- With pready=1 in the first ACCESS cycle, completion is at edge N+3 and rsp_valid=1 in cycle N+3.
- Minimum is 3 cycles per transfer. Each pready=0 cycle adds one.
- A new command may be accepted in the same cycle that rsp_valid=1.
- preset asserted mid-transfer: at the next edge, psel=penable=0, state=IDLE, and no rsp_valid for the aborted transfer.
- pready/pslverr are sampled only in ACCESS; they are ignored in IDLE/SETUP.

## Configuration
- APB_TIMEOUT_EN defined:
  - The counter clears on entry to ACCESS and increments on each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT_CYC with pready still 0, the transfer is abandoned at that edge: state=IDLE, psel=penable=0.
  - The next cycle has rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - pready=1 on the same edge as the limit wins: normal completion.
- APB_TIMEOUT_EN undefined:
  - No counter; ACCESS waits indefinitely.
  - rsp_timeout is tied 0.
  - TIMEOUT_CYC is unused.

## Test plan
- Write, no wait: DATA_W=32, addr 0x24, wdata 0xDEADBEEF, strb 0xF, prot 3'b010, pready=1.
  - Required: psel 1 in N+1, penable 1 in N+2, pstrb=0xF, pprot=2, rsp_valid in N+3, rsp_err=0.
- Read with 2 wait states: addr 0x10, prdata=0x32, pready low for 2 ACCESS cycles.
  - Required: rsp_valid in N+5, rsp_rdata=0x32, pstrb=0 throughout.
- Slave error: write with pslverr=1 at pready.
  - Required: rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- Back-to-back: cmd_valid held with two queued commands (write 0x01, read 0x02).
  - Required: second handshake in the same cycle as the first rsp_valid, second SETUP in the next cycle, psel low exactly one cycle between transfers.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYC=4): pready held 0.
  - Required: abort after 4 ACCESS cycles, rsp_err=1, rsp_timeout=1.
  - Repeat with pready=1 on the 4th cycle: normal completion, rsp_timeout=0.
  - Without the macro: still in ACCESS after 100 cycles.
- Reset mid-ACCESS: assert preset during wait states.
  - Required: next cycle psel=penable=0, cmd_ready=1 after release, no rsp_valid.
